// File: rtl/decode_stage.sv
// decode_stage: RV32 integer decode stage. Decodes R-type and I-type ALU
// instructions, reads two operands from an internal register file with
// write-through forwarding, and presents a registered bundle to the ALU
// stage over a valid/ready handshake with one cycle of latency.
module decode_stage #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     instr,
   input  logic            wb_en,
   input  logic [4:0]      wb_addr,
   input  logic [XLEN-1:0] wb_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] op_a,
   output logic [XLEN-1:0] op_b,
   output logic [4:0]      rd,
   output logic [3:0]      alu_ctrl,
   output logic            is_imm,
   output logic            illegal
);
   localparam int         AW      = $clog2(NREGS);
   localparam int         SHW     = (XLEN == 64) ? 6 : 5;
   localparam bit         XLEN64  = (XLEN == 64);
   localparam logic [5:0] NREGS_W = 6'(NREGS);
   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;

   logic [XLEN-1:0] regs_r [NREGS];
   logic            out_valid_r;
   logic [XLEN-1:0] op_a_r;
   logic [XLEN-1:0] op_b_r;
   logic [4:0]      rd_r;
   logic [3:0]      alu_ctrl_r;
   logic            is_imm_r;
   logic            illegal_r;

   logic [6:0]      opcode_s;
   logic [2:0]      funct3_s;
   logic [6:0]      funct7_s;
   logic [4:0]      rs1_s;
   logic [4:0]      rs2_s;
   logic [4:0]      rd_s;
   logic            rs1_ok_s;
   logic            rs2_ok_s;
   logic            rd_ok_s;
   logic            r_funct_ok_s;
   logic            is_shift_s;
   logic            shift_ok_s;
   logic            shamt_hi_ok_s;
   logic [XLEN-1:0] imm_ext_s;
   logic [XLEN-1:0] shamt_ext_s;
   logic [XLEN-1:0] rs1_val_s;
   logic [XLEN-1:0] rs2_val_s;
   logic            wb_commit_s;
   logic            accept_s;
   logic            dec_illegal_s;
   logic [XLEN-1:0] dec_op_b_s;
   logic [3:0]      dec_ctrl_s;
   logic            dec_is_imm_s;

   assign opcode_s = instr[6:0];
   assign rd_s     = instr[11:7];
   assign funct3_s = instr[14:12];
   assign rs1_s    = instr[19:15];
   assign rs2_s    = instr[24:20];
   assign funct7_s = instr[31:25];

   assign rs1_ok_s = ({1'b0, rs1_s} < NREGS_W);
   assign rs2_ok_s = ({1'b0, rs2_s} < NREGS_W);
   assign rd_ok_s  = ({1'b0, rd_s}  < NREGS_W);

   // SUB and SRA are the only R-type ops that use the alternate funct7
   assign r_funct_ok_s = (funct7_s == 7'b0000000) ||
                         ((funct7_s == 7'b0100000) &&
                          ((funct3_s == 3'b000) || (funct3_s == 3'b101)));

   // On RV32 instr[25] would be a sixth shamt bit, which is not allowed
   assign is_shift_s    = (funct3_s == 3'b001) || (funct3_s == 3'b101);
   assign shamt_hi_ok_s = XLEN64 ? 1'b1 : !instr[25];
   assign shift_ok_s    = shamt_hi_ok_s &&
                          ((instr[31:26] == 6'b000000) ||
                           ((funct3_s == 3'b101) && (instr[31:26] == 6'b010000)));

   assign imm_ext_s   = {{(XLEN-12){instr[31]}}, instr[31:20]};
   assign shamt_ext_s = {{(XLEN-SHW){1'b0}}, instr[20+SHW-1:20]};

   assign wb_commit_s = wb_en && (wb_addr != 5'd0) && ({1'b0, wb_addr} < NREGS_W);
   assign in_ready    = !out_valid_r || out_ready;
   assign accept_s    = in_valid && in_ready;

   // Register file write port; x0 and out-of-range indices are never written
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_r[i] <= {XLEN{1'b0}};
         end
      end else if (wb_commit_s) begin
         regs_r[wb_addr[AW-1:0]] <= wb_data;
      end else begin
         regs_r <= regs_r;
      end
   end

   // Read port A: x0 reads zero, a same-cycle writeback is forwarded
   always_comb begin
      rs1_val_s = {XLEN{1'b0}};
      if ((rs1_s == 5'd0) || !rs1_ok_s) begin
         rs1_val_s = {XLEN{1'b0}};
      end else if (wb_en && (wb_addr == rs1_s)) begin
         rs1_val_s = wb_data;
      end else begin
         rs1_val_s = regs_r[rs1_s[AW-1:0]];
      end
   end

   // Read port B: x0 reads zero, a same-cycle writeback is forwarded
   always_comb begin
      rs2_val_s = {XLEN{1'b0}};
      if ((rs2_s == 5'd0) || !rs2_ok_s) begin
         rs2_val_s = {XLEN{1'b0}};
      end else if (wb_en && (wb_addr == rs2_s)) begin
         rs2_val_s = wb_data;
      end else begin
         rs2_val_s = regs_r[rs2_s[AW-1:0]];
      end
   end

   // Instruction decode: legality, second operand and ALU control
   always_comb begin
      dec_illegal_s = 1'b1;
      dec_op_b_s    = {XLEN{1'b0}};
      dec_ctrl_s    = 4'b0000;
      dec_is_imm_s  = 1'b0;
      case (opcode_s)
         OP_R: begin
            dec_illegal_s = !(r_funct_ok_s && rs1_ok_s && rs2_ok_s && rd_ok_s);
            dec_op_b_s    = rs2_val_s;
            dec_ctrl_s    = {instr[30], funct3_s};
            dec_is_imm_s  = 1'b0;
         end
         OP_I: begin
            dec_is_imm_s = 1'b1;
            if (is_shift_s) begin
               dec_illegal_s = !(shift_ok_s && rs1_ok_s && rd_ok_s);
               dec_op_b_s    = shamt_ext_s;
               dec_ctrl_s    = {instr[30], funct3_s};
            end else begin
               dec_illegal_s = !(rs1_ok_s && rd_ok_s);
               dec_op_b_s    = imm_ext_s;
               dec_ctrl_s    = {1'b0, funct3_s};
            end
         end
         default: begin
            dec_illegal_s = 1'b1;
            dec_op_b_s    = {XLEN{1'b0}};
            dec_ctrl_s    = 4'b0000;
            dec_is_imm_s  = 1'b0;
         end
      endcase
   end

   // Output bundle register: capture on accept, hold while stalled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_r <= 1'b0;
         op_a_r      <= {XLEN{1'b0}};
         op_b_r      <= {XLEN{1'b0}};
         rd_r        <= 5'd0;
         alu_ctrl_r  <= 4'b0000;
         is_imm_r    <= 1'b0;
         illegal_r   <= 1'b0;
      end else if (accept_s) begin
         out_valid_r <= 1'b1;
         illegal_r   <= dec_illegal_s;
         if (dec_illegal_s) begin
            op_a_r     <= {XLEN{1'b0}};
            op_b_r     <= {XLEN{1'b0}};
            rd_r       <= 5'd0;
            alu_ctrl_r <= 4'b0000;
            is_imm_r   <= 1'b0;
         end else begin
            op_a_r     <= rs1_val_s;
            op_b_r     <= dec_op_b_s;
            rd_r       <= rd_s;
            alu_ctrl_r <= dec_ctrl_s;
            is_imm_r   <= dec_is_imm_s;
         end
      end else if (out_ready) begin
         out_valid_r <= 1'b0;
      end else begin
         out_valid_r <= out_valid_r;
      end
   end

   assign out_valid = out_valid_r;
   assign op_a      = op_a_r;
   assign op_b      = op_b_r;
   assign rd        = rd_r;
   assign alu_ctrl  = alu_ctrl_r;
   assign is_imm    = is_imm_r;
   assign illegal   = illegal_r;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed pins plus randomized traffic for decode_stage,
// checked every cycle against a behavioural model of the decode rules.
module tb_decode_stage;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] instr = 32'd0;
   logic        wb_en = 1'b0;
   logic [4:0]  wb_addr = 5'd0;
   logic [31:0] wb_data = 32'd0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] op_a, op_b;
   logic [4:0]  rd;
   logic [3:0]  alu_ctrl;
   logic        is_imm, illegal;

   logic        in_ready16, out_valid16, is_imm16, illegal16;
   logic [31:0] op_a16, op_b16;
   logic [4:0]  rd16;
   logic [3:0]  alu_ctrl16;

   int total = 0;
   int bad = 0;

   decode_stage #(.XLEN(32), .NREGS(32)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .instr(instr), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .out_valid(out_valid), .out_ready(out_ready), .op_a(op_a), .op_b(op_b),
      .rd(rd), .alu_ctrl(alu_ctrl), .is_imm(is_imm), .illegal(illegal));

   decode_stage #(.XLEN(32), .NREGS(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready16),
      .instr(instr), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .out_valid(out_valid16), .out_ready(out_ready), .op_a(op_a16), .op_b(op_b16),
      .rd(rd16), .alu_ctrl(alu_ctrl16), .is_imm(is_imm16), .illegal(illegal16));

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      logic [3:0]  ctrl;
      logic        imm;
      logic        ill;
   } bundle_t;

   logic [31:0] mregs [32];
   logic        m_valid;
   bundle_t     m_b;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // architectural register read as seen this cycle, including writeback bypass
   function automatic logic [31:0] rdreg(input logic [4:0] idx);
      if (idx == 5'd0) return 32'd0;
      if (wb_en && wb_addr == idx) return wb_data;
      return mregs[idx];
   endfunction

   function automatic bundle_t model_decode(input logic [31:0] ins);
      bundle_t     b;
      logic [6:0]  opc;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic        ok;
      b   = '0;
      ok  = 1'b0;
      opc = ins[6:0];
      f3  = ins[14:12];
      f7  = ins[31:25];
      if (opc == 7'h33) begin
         ok     = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
         b.b    = rdreg(ins[24:20]);
         b.ctrl = {ins[30], f3};
      end else if (opc == 7'h13) begin
         b.imm = 1'b1;
         if (f3 == 3'd1 || f3 == 3'd5) begin
            ok     = (f7 == 7'h00) || (f3 == 3'd5 && f7 == 7'h20);
            b.b    = 32'(ins[24:20]);
            b.ctrl = {ins[30], f3};
         end else begin
            ok     = 1'b1;
            b.b    = 32'($signed(ins[31:20]));
            b.ctrl = {1'b0, f3};
         end
      end
      if (ok) begin
         b.a  = rdreg(ins[19:15]);
         b.rd = ins[11:7];
      end else begin
         b     = '0;
         b.ill = 1'b1;
      end
      return b;
   endfunction

   // behavioural reference: one bundle slot plus the register array
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid <= 1'b0;
         m_b     <= '0;
         for (int i = 0; i < 32; i++) mregs[i] <= 32'd0;
      end else begin
         if (in_valid && (!m_valid || out_ready)) begin
            m_b     <= model_decode(instr);
            m_valid <= 1'b1;
         end else if (out_ready) begin
            m_valid <= 1'b0;
         end
         if (wb_en && wb_addr != 5'd0) mregs[wb_addr] <= wb_data;
      end
   end

   // per-cycle comparison of the DUT against the reference
   always @(negedge clk) begin
      chk("cyc_out_valid", 64'(out_valid), 64'(m_valid));
      chk("cyc_in_ready",  64'(in_ready),  64'(!m_valid || out_ready));
      chk("cyc_op_a",      64'(op_a),      64'(m_b.a));
      chk("cyc_op_b",      64'(op_b),      64'(m_b.b));
      chk("cyc_rd",        64'(rd),        64'(m_b.rd));
      chk("cyc_alu_ctrl",  64'(alu_ctrl),  64'(m_b.ctrl));
      chk("cyc_is_imm",    64'(is_imm),    64'(m_b.imm));
      chk("cyc_illegal",   64'(illegal),   64'(m_b.ill));
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   function automatic logic [31:0] gen_instr();
      logic [31:0] w;
      int          k;
      int          r;
      w = $urandom;
      k = $urandom_range(0, 9);
      r = $urandom_range(0, 3);
      if (k <= 3) begin
         w[6:0] = 7'h33;
         if (r <= 1) w[31:25] = 7'h00;
         else if (r == 2) w[31:25] = 7'h20;
      end else if (k <= 6) begin
         w[6:0] = 7'h13;
      end else if (k <= 8) begin
         w[6:0]   = 7'h13;
         w[14:12] = ($urandom_range(0, 1) == 1) ? 3'b001 : 3'b101;
         if (r <= 1) w[31:25] = 7'h00;
         else if (r == 2) w[31:25] = 7'h20;
      end
      return w;
   endfunction

   initial begin
      // reset state
      #3;
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      repeat (3) step();
      rst_n = 1'b1;

      // ADD x3,x1,x2 right after reset: registers read zero
      in_valid = 1'b1; out_ready = 1'b1; instr = 32'h002081B3;
      step();
      chk("add_valid", 64'(out_valid), 64'd1);
      chk("add_op_a", 64'(op_a), 64'd0);
      chk("add_op_b", 64'(op_b), 64'd0);
      chk("add_rd", 64'(rd), 64'd3);
      chk("add_ctrl", 64'(alu_ctrl), 64'd0);
      chk("add_imm", 64'(is_imm), 64'd0);

      // write x1=5, x2=7, then SUB
      in_valid = 1'b0; wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'd5;
      step();
      wb_addr = 5'd2; wb_data = 32'd7;
      step();
      wb_en = 1'b0; in_valid = 1'b1; instr = 32'h402081B3;
      step();
      chk("sub_op_a", 64'(op_a), 64'd5);
      chk("sub_op_b", 64'(op_b), 64'd7);
      chk("sub_ctrl", 64'(alu_ctrl), 64'h8);
      // forwarded writeback in the issue cycle
      wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'd9;
      step();
      wb_en = 1'b0;
      chk("fwd_op_a", 64'(op_a), 64'd9);
      chk("fwd_op_b", 64'(op_b), 64'd7);

      // immediates
      instr = 32'hFFF00293;
      step();
      chk("addi_op_a", 64'(op_a), 64'd0);
      chk("addi_op_b", 64'(op_b), 64'hFFFFFFFF);
      chk("addi_imm", 64'(is_imm), 64'd1);
      chk("addi_rd", 64'(rd), 64'd5);
      instr = 32'h4032D313;
      step();
      chk("srai_op_b", 64'(op_b), 64'd3);
      chk("srai_ctrl", 64'(alu_ctrl), 64'hD);
      chk("srai_rd", 64'(rd), 64'd6);
      instr = 32'h00109093;
      step();
      chk("slli_op_a", 64'(op_a), 64'd9);
      chk("slli_op_b", 64'(op_b), 64'd1);
      chk("slli_ctrl", 64'(alu_ctrl), 64'h1);

      // x0 is never written nor forwarded
      in_valid = 1'b0; wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hDEAD;
      step();
      in_valid = 1'b1; instr = 32'h000001B3;
      step();
      wb_en = 1'b0;
      chk("x0_op_a", 64'(op_a), 64'd0);
      chk("x0_op_b", 64'(op_b), 64'd0);

      // illegal encodings
      instr = 32'h0000006F;
      step();
      chk("jal_illegal", 64'(illegal), 64'd1);
      chk("jal_rd", 64'(rd), 64'd0);
      chk("jal_valid", 64'(out_valid), 64'd1);
      instr = 32'h02109093;
      step();
      chk("slli25_illegal", 64'(illegal), 64'd1);
      chk("slli25_op_a", 64'(op_a), 64'd0);

      // backpressure: hold 3 cycles, nothing lost
      in_valid = 1'b0;
      step();
      out_ready = 1'b0; in_valid = 1'b1; instr = 32'h00100093;
      step();
      chk("bp_first_rd", 64'(rd), 64'd1);
      instr = 32'h00200113;
      for (int i = 0; i < 3; i++) begin
         chk("bp_in_ready", 64'(in_ready), 64'd0);
         step();
         chk("bp_hold_rd", 64'(rd), 64'd1);
         chk("bp_hold_op_b", 64'(op_b), 64'd1);
      end
      out_ready = 1'b1;
      step();
      chk("bp_second_rd", 64'(rd), 64'd2);
      instr = 32'h00300193;
      step();
      chk("bp_third_rd", 64'(rd), 64'd3);
      chk("bp_third_op_b", 64'(op_b), 64'd3);
      in_valid = 1'b0;
      step();
      chk("drain_valid", 64'(out_valid), 64'd0);
      chk("drain_hold_rd", 64'(rd), 64'd3);

      // asynchronous reset during a stall
      out_ready = 1'b0; in_valid = 1'b1; instr = 32'h002081B3;
      step();
      chk("stall_valid", 64'(out_valid), 64'd1);
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", 64'(out_valid), 64'd0);
      chk("arst_in_ready", 64'(in_ready), 64'd1);
      #1;
      rst_n = 1'b1;
      out_ready = 1'b1; in_valid = 1'b1; instr = 32'h002081B3;
      step();
      chk("arst_op_a", 64'(op_a), 64'd0);
      chk("arst_op_b", 64'(op_b), 64'd0);

      // RV32E instance: rs1=17 is out of range
      instr = 32'h002881B3;
      step();
      chk("e_illegal", 64'(illegal16), 64'd1);
      chk("e_rd", 64'(rd16), 64'd0);
      chk("e_valid", 64'(out_valid16), 64'd1);
      chk("i_legal", 64'(illegal), 64'd0);

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 9) < 7);
         instr     = gen_instr();
         wb_en     = ($urandom_range(0, 1) == 1);
         wb_addr   = 5'($urandom_range(0, 31));
         wb_data   = $urandom;
         step();
      end
      in_valid = 1'b0; wb_en = 1'b0; out_ready = 1'b1;
      step();
      step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
